// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the CCC dynamic-configuration port: holds the PLL in reset, loads a
// register table (optionally reading each entry back), then releases the PLL and waits for lock.
module ccc_apb_cfg_master #(
  parameter int NUM_REGS  = 8,
  parameter int VERIFY    = 1,
  parameter int TIMEOUT   = 65535,
  parameter int LOCK_FILT = 4,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          START,
  output logic [IW-1:0] CFG_IDX,
  input  logic [5:0]    CFG_ADDR,
  input  logic [7:0]    CFG_DATA,
  input  logic [7:0]    CFG_MASK,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [5:0]    PADDR,
  output logic [7:0]    PWDATA,
  input  logic [7:0]    PRDATA,
  input  logic          BUSY,
  input  logic          LOCK,
  output logic          PLL_ARST_N,
  output logic          DONE,
  output logic          ERR,
  output logic [1:0]    ERR_CODE,
  output logic [IW-1:0] ERR_IDX
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
  localparam logic [FW-1:0] FLAST    = FW'(LOCK_FILT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_BUSY = 4'd1;
  localparam logic [3:0] S_SETUP_W   = 4'd2;
  localparam logic [3:0] S_ACCESS_W  = 4'd3;
  localparam logic [3:0] S_SETUP_R   = 4'd4;
  localparam logic [3:0] S_ACCESS_R  = 4'd5;
  localparam logic [3:0] S_NEXT      = 4'd6;
  localparam logic [3:0] S_RELEASE   = 4'd7;
  localparam logic [3:0] S_WAIT_LOCK = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;
  localparam logic [3:0] S_FAIL      = 4'd10;

  localparam logic [1:0] E_BUSY = 2'b01;
  localparam logic [1:0] E_LOCK = 2'b10;
  localparam logic [1:0] E_RDBK = 2'b11;

  logic [3:0]    state;
  logic [TW-1:0] timer;
  logic [FW-1:0] filt;

  function automatic logic readback_bad(input logic [7:0] rd, input logic [7:0] wr,
                                        input logic [7:0] mask);
    return ((rd ^ wr) & mask) != 8'h00;
  endfunction

  // APB outputs are registered so they reflect the state being entered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= S_IDLE;
      timer      <= '0;
      filt       <= '0;
      CFG_IDX    <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PLL_ARST_N <= 1'b1;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= '0;
      ERR_IDX    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (START) begin
            state      <= S_WAIT_BUSY;
            CFG_IDX    <= '0;
            PLL_ARST_N <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            ERR_CODE   <= '0;
            timer      <= '0;
          end
        end
        S_WAIT_BUSY: begin
          if (!BUSY) begin
            state   <= S_SETUP_W;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b1;
            PADDR   <= CFG_ADDR;
            PWDATA  <= CFG_DATA;
          end else if (timer == TMAX) begin
            state    <= S_FAIL;
            ERR      <= 1'b1;
            ERR_CODE <= E_BUSY;
            ERR_IDX  <= CFG_IDX;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SETUP_W: begin
          state   <= S_ACCESS_W;
          PENABLE <= 1'b1;
        end
        S_ACCESS_W: begin
          PENABLE <= 1'b0;
          if (VERIFY != 0) begin
            state  <= S_SETUP_R;
            PWRITE <= 1'b0;
          end else begin
            state <= S_NEXT;
            PSEL  <= 1'b0;
          end
        end
        S_SETUP_R: begin
          state   <= S_ACCESS_R;
          PENABLE <= 1'b1;
        end
        S_ACCESS_R: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (readback_bad(PRDATA, CFG_DATA, CFG_MASK)) begin
            state    <= S_FAIL;
            ERR      <= 1'b1;
            ERR_CODE <= E_RDBK;
            ERR_IDX  <= CFG_IDX;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (CFG_IDX == LAST_IDX) begin
            state <= S_RELEASE;
          end else begin
            state   <= S_WAIT_BUSY;
            CFG_IDX <= CFG_IDX + IW'(1);
            timer   <= '0;
          end
        end
        S_RELEASE: begin
          state      <= S_WAIT_LOCK;
          PLL_ARST_N <= 1'b1;
          timer      <= '0;
          filt       <= '0;
        end
        S_WAIT_LOCK: begin
          // The timer keeps running across LOCK drops; only the filter restarts.
          if (LOCK && filt == FLAST) begin
            state <= S_DONE;
            DONE  <= 1'b1;
          end else if (timer == TMAX) begin
            state    <= S_FAIL;
            ERR      <= 1'b1;
            ERR_CODE <= E_LOCK;
            ERR_IDX  <= CFG_IDX;
          end else begin
            timer <= timer + TW'(1);
            filt  <= LOCK ? filt + FW'(1) : '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Bench for ccc_apb_cfg_master: scenario table plus APB scoreboard, and hand-written
// sequences for restart, mid-sequence reset and the write-only single-entry build.
module tb_ccc_apb_cfg_master;

  localparam int NREG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [2:0] cfg_idx, err_idx;
  logic [5:0] cfg_addr, paddr;
  logic [7:0] cfg_data, cfg_mask, pwdata, prdata;
  logic       psel, penable, pwrite, busy, lock, pll_arst_n, done, err;
  logic [1:0] err_code;

  logic       start2, psel2, penable2, pwrite2, pll2, done2, err2;
  logic [0:0] cfg_idx2, err_idx2;
  logic [5:0] paddr2;
  logic [7:0] pwdata2;
  logic [1:0] err_code2;

  logic [5:0] tbl_addr [NREG];
  logic [7:0] tbl_data [NREG];
  logic [7:0] mask5;
  logic [7:0] ccc_mem [64];
  int cyc = 0;
  int e0, e0b;
  int stall_on, corrupt_on, tog_on, busy_all;
  logic tog = 1'b0;
  int tcnt = 0;

  int n_cmp, n_fail, v0_acc;

  typedef struct packed { logic w; logic [5:0] addr; logic [7:0] data; } xfer_t;
  xfer_t exp_q[$];
  xfer_t mon_e;

  typedef struct {
    int stall, corrupt, tog, busy_all;
    logic [7:0] mask5;
    logic exp_err;
    logic [1:0] exp_code;
    logic [2:0] exp_idx;
    int exp_k, exp_rise;
    logic exp_arst;
    int exp_xfers;
  } vec_t;
  vec_t vecs[6];

  ccc_apb_cfg_master #(.NUM_REGS(8), .VERIFY(1), .TIMEOUT(100), .LOCK_FILT(4)) dut (
    .PCLK(clk), .PRESET(rst), .START(start), .CFG_IDX(cfg_idx), .CFG_ADDR(cfg_addr),
    .CFG_DATA(cfg_data), .CFG_MASK(cfg_mask), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .BUSY(busy),
    .LOCK(lock), .PLL_ARST_N(pll_arst_n), .DONE(done), .ERR(err), .ERR_CODE(err_code),
    .ERR_IDX(err_idx));

  ccc_apb_cfg_master #(.NUM_REGS(1), .VERIFY(0), .TIMEOUT(65535), .LOCK_FILT(4)) dut_wo (
    .PCLK(clk), .PRESET(rst), .START(start2), .CFG_IDX(cfg_idx2), .CFG_ADDR(6'h2A),
    .CFG_DATA(8'h3C), .CFG_MASK(8'hFF), .PSEL(psel2), .PENABLE(penable2),
    .PWRITE(pwrite2), .PADDR(paddr2), .PWDATA(pwdata2), .PRDATA(8'h00), .BUSY(1'b0),
    .LOCK(pll2), .PLL_ARST_N(pll2), .DONE(done2), .ERR(err2), .ERR_CODE(err_code2),
    .ERR_IDX(err_idx2));

  // Environment: combinational config table, echoing CCC register file, BUSY/LOCK stimulus.
  assign cfg_addr = tbl_addr[cfg_idx];
  assign cfg_data = tbl_data[cfg_idx];
  assign cfg_mask = (cfg_idx == 3'd5) ? mask5 : 8'hFF;
  assign prdata   = ccc_mem[paddr] ^ ((corrupt_on != 0 && paddr == tbl_addr[5]) ? 8'h04 : 8'h00);
  assign busy     = (busy_all != 0) || (stall_on != 0 && cyc >= e0 + 18 && cyc < e0 + 28);
  assign lock     = pll_arst_n && (tog_on == 0 || tog);

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (psel && penable && pwrite) ccc_mem[paddr] <= pwdata;
  always @(negedge clk) begin
    if (tcnt == 2) begin
      tcnt <= 0;
      tog  <= ~tog;
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_entries(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, tbl_addr[i], tbl_data[i]});
      exp_q.push_back({1'b0, tbl_addr[i], 8'h00});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_wait(output int k_end, output int k_rise);
    logic prev;
    prev = pll_arst_n;
    k_end = -1;
    k_rise = -1;
    for (int i = 0; i < 400; i++) begin
      if (!prev && pll_arst_n) k_rise = cyc - e0;
      prev = pll_arst_n;
      if (done || err) begin
        k_end = cyc - e0;
        break;
      end
      @(negedge clk);
    end
    if (k_end < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: no DONE/ERR within 400 cycles");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_end, k_rise;
    n_cmp = 0; n_fail = 0; v0_acc = 0;
    for (int i = 0; i < NREG; i++) begin
      tbl_addr[i] = 6'(i * 5 + 3);
      tbl_data[i] = 8'hA5 ^ 8'(i * 37);
    end
    //            stall corr tog ball mask5  err code idx  k   rise arst xfers
    vecs[0] = '{0, 0, 0, 0, 8'hFF, 1'b0, 2'd0, 3'd0, 53,  49, 1'b1, 16};
    vecs[1] = '{1, 0, 0, 0, 8'hFF, 1'b0, 2'd0, 3'd0, 63,  59, 1'b1, 16};
    vecs[2] = '{0, 1, 0, 0, 8'hFF, 1'b1, 2'd3, 3'd5, 35,  -1, 1'b0, 12};
    vecs[3] = '{0, 1, 0, 0, 8'hFB, 1'b0, 2'd0, 3'd0, 53,  49, 1'b1, 16};
    vecs[4] = '{0, 0, 1, 0, 8'hFF, 1'b1, 2'd2, 3'd7, 150, 49, 1'b1, 16};
    vecs[5] = '{0, 0, 0, 1, 8'hFF, 1'b1, 2'd1, 3'd0, 101, -1, 1'b0, 0};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; mask5 = 8'hFF; e0 = 0; e0b = 0;
    stall_on = 0; corrupt_on = 0; tog_on = 0; busy_all = 0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (busy) check("busy_no_psel", 32'(psel), 32'd0);
          if (psel && penable) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_xfer: got w=%0b addr=%0h expected none", pwrite, paddr);
            end else begin
              mon_e = exp_q.pop_front();
              check("apb_xfer", 32'({pwrite, paddr, (pwrite ? pwdata : 8'h00)}), 32'(mon_e));
            end
          end
          if (psel2) check("wo_pwrite", 32'(pwrite2), 32'd1);
          if (psel2 && penable2) begin
            v0_acc++;
            check("wo_xfer", 32'({paddr2, pwdata2}), 32'({6'h2A, 8'h3C}));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_apb", 32'({psel, penable, pwrite, paddr, pwdata}), 32'd0);
    check("rst_status", 32'({pll_arst_n, done, err, err_code, err_idx, cfg_idx}), 32'h400);
    check("rst_wo", 32'({psel2, pll2, done2, err2}), 32'b0100);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      stall_on = vecs[v].stall; corrupt_on = vecs[v].corrupt;
      tog_on = vecs[v].tog; busy_all = vecs[v].busy_all; mask5 = vecs[v].mask5;
      push_entries(vecs[v].exp_xfers / 2);
      pulse_start();
      run_wait(k_end, k_rise);
      check($sformatf("v%0d_end_cycle", v), 32'(k_end), 32'(vecs[v].exp_k));
      check($sformatf("v%0d_release_cycle", v), 32'(k_rise), 32'(vecs[v].exp_rise));
      check($sformatf("v%0d_done_err", v), 32'({done, err}), 32'({~vecs[v].exp_err, vecs[v].exp_err}));
      check($sformatf("v%0d_err_code", v), 32'(err_code), 32'(vecs[v].exp_code));
      if (vecs[v].exp_err) check($sformatf("v%0d_err_idx", v), 32'(err_idx), 32'(vecs[v].exp_idx));
      check($sformatf("v%0d_pll_arst_n", v), 32'(pll_arst_n), 32'(vecs[v].exp_arst));
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_xfers_left", v), 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      stall_on = 0; corrupt_on = 0; tog_on = 0; busy_all = 0; mask5 = 8'hFF;
    end

    // START during entry 2 must not disturb the sequence.
    push_entries(NREG);
    pulse_start();
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_wait(k_end, k_rise);
    check("ign_start_end", 32'(k_end), 32'd53);
    check("ign_start_err", 32'(err), 32'd0);
    check("ign_start_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // PRESET in the middle of entry 4's write.
    push_entries(NREG);
    pulse_start();
    repeat (25) @(negedge clk);
    check("mid_xfer_psel", 32'({psel, pwrite, paddr}), 32'({1'b1, 1'b1, tbl_addr[4]}));
    rst = 1'b1;
    @(negedge clk);
    check("prst_apb", 32'({psel, penable, pwrite, paddr, pwdata}), 32'd0);
    check("prst_status", 32'({pll_arst_n, done, err, err_code, err_idx, cfg_idx}), 32'h400);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("idle_after_prst", 32'({psel, pll_arst_n, done}), 32'b010);

    push_entries(NREG);
    pulse_start();
    run_wait(k_end, k_rise);
    check("post_rst_end", 32'(k_end), 32'd53);
    check("post_rst_release", 32'(k_rise), 32'd49);
    check("post_rst_done", 32'({done, err}), 32'b10);

    // START while DONE: DONE clears and the PLL goes back into reset immediately.
    repeat (2) @(negedge clk);
    check("post_rst_left", 32'(exp_q.size()), 32'd0);
    push_entries(NREG);
    pulse_start();
    check("restart_clears", 32'({done, pll_arst_n}), 32'b00);
    run_wait(k_end, k_rise);
    check("restart_end", 32'(k_end), 32'd53);
    repeat (2) @(negedge clk);
    check("restart_left", 32'(exp_q.size()), 32'd0);

    // Write-only, single-entry build.
    start2 = 1'b1;
    e0b = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    k_end = -1;
    k_rise = -1;
    for (int i = 0; i < 100; i++) begin
      if (pll2 && k_rise < 0) k_rise = cyc - e0b;
      if (done2) begin
        k_end = cyc - e0b;
        break;
      end
      @(negedge clk);
    end
    check("wo_done_cycle", 32'(k_end), 32'd9);
    check("wo_release_cycle", 32'(k_rise), 32'd5);
    check("wo_err", 32'(err2), 32'd0);
    check("wo_xfer_count", 32'(v0_acc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
